despread_integrator: RTL and testbench

//  Parametrised I/Q despreader with integrate-and-dump. Each accepted chip is multiplied by
//  the local code (+1 when local_code=1, -1 when 0). The products are accumulated over a
//  run-time window of int_len chips. At window end the block dumps the I/Q sums, |I|+|Q|
//  and a threshold flag. Sits between the chip-rate sample front end and acquisition/tracking.

---
 rtl/corr_pkg.sv | 36 +++
 rtl/despread_sat_acc.sv | 48 ++++
 rtl/despread_integrator.sv | 150 +++++++++++++++
 tb/tb_despread_integrator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and arithmetic helpers for the despread/correlate datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package corr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Local code chip value that leaves the sample un-negated.
  localparam logic CODE_POS = 1'b1;

  // Add two sign-extended values and clamp to the symmetric range
  // +/-(2^(width-1)-1). Callers keep the low bits they need. width <= 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 width);
    logic signed [32:0] s;
    logic signed [32:0] lim;
    s   = {a[31], a} + {b[31], b};
    lim = (33'sd1 <<< (width - 1)) - 33'sd1;
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s[31:0];
  endfunction

  // Magnitude of a signed value; inputs are never the most negative value here.
  function automatic logic [31:0] abs_val(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/despread_sat_acc.sv
// One channel: despread by local code, saturating accumulate, sticky saturation flag.
// Latency: acc_next/sat_next are combinational views of the sum including the current chip.
// Backpressure: none; en qualifies the chip, clear has priority over en.
module despread_sat_acc
  import corr_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  sample,
  input  logic                    code,
  output logic signed [ACC_W-1:0] acc_next,
  output logic                    sat_next
);

  logic signed [ACC_W-1:0] acc;
  logic                    sat;
  logic signed [IN_W:0]    s_ext;
  logic signed [IN_W:0]    prod;
  logic signed [31:0]      sum_raw;
  logic signed [31:0]      sum_clamped;

  // Widen before negating so the most negative sample flips exactly.
  always_comb begin
    s_ext       = {sample[IN_W-1], sample};
    prod        = (code == CODE_POS) ? s_ext : -s_ext;
    sum_raw     = 32'(acc) + 32'(prod);
    sum_clamped = sat_add(32'(acc), 32'(prod), ACC_W);
    acc_next    = ACC_W'(sum_clamped);
    sat_next    = sat | (sum_clamped != sum_raw);
  end

  // Accumulator and sticky saturation; clear starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= acc_next;
      sat <= sat_next;
    end
  end

endmodule

// File: rtl/despread_integrator.sv
// I/Q despreader with run-time integrate-and-dump window, |I|+|Q| and threshold detect.
// Latency: out_valid two cycles after the cycle presenting the window's last chip.
// Backpressure: none; every in_valid chip in RUN is consumed, windows dump back-to-back.
module despread_integrator
  import corr_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int ACC_W = 16,
  parameter int LEN_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        int_len,
  input  logic [ACC_W-1:0]        threshold,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  I_in,
  input  logic signed [IN_W-1:0]  Q_in,
  input  logic                    local_code,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] I_acc,
  output logic signed [ACC_W-1:0] Q_acc,
  output logic [ACC_W:0]          mag,
  output logic                    over_thresh,
  output logic                    sat
);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q;
  logic [ACC_W-1:0]        thr_q;
  logic [LEN_W-1:0]        cnt_q;
  logic                    accept;
  logic                    last;
  logic                    clear;
  logic signed [ACC_W-1:0] i_next, q_next;
  logic                    i_sat_next, q_sat_next;

  logic                    s1_vld;
  logic signed [ACC_W-1:0] s1_i, s1_q;
  logic                    s1_sat;
  logic [ACC_W-1:0]        s1_thr;
  logic [ACC_W:0]          mag_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start enters or restarts RUN; only reset leaves it.
  always_comb begin
    state_d = state_q;
    if (start) state_d = RUN;
  end

  // A start cycle discards its chip; the window ends on chip int_len-1.
  always_comb begin
    busy   = (state_q == RUN);
    accept = (state_q == RUN) && in_valid && !start;
    last   = accept && (cnt_q == (len_q - LEN_W'(1)));
    clear  = start || last;
  end

  // Window configuration captured on start; a zero length behaves as one chip.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= LEN_W'(1);
      thr_q <= '0;
    end else if (start) begin
      len_q <= (int_len == '0) ? LEN_W'(1) : int_len;
      thr_q <= threshold;
    end
  end

  // Chip counter within the current window.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt_q <= '0;
    else if (accept)  cnt_q <= cnt_q + LEN_W'(1);
  end

  despread_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_i (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .en       (accept),
    .sample   (I_in),
    .code     (local_code),
    .acc_next (i_next),
    .sat_next (i_sat_next)
  );

  despread_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_q (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .en       (accept),
    .sample   (Q_in),
    .code     (local_code),
    .acc_next (q_next),
    .sat_next (q_sat_next)
  );

  // Stage 1: capture final sums including the last chip; threshold travels with them
  // so a restart arriving now does not alter this window's decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_i   <= '0;
      s1_q   <= '0;
      s1_sat <= 1'b0;
      s1_thr <= '0;
    end else begin
      s1_vld <= last;
      if (last) begin
        s1_i   <= i_next;
        s1_q   <= q_next;
        s1_sat <= i_sat_next | q_sat_next;
        s1_thr <= thr_q;
      end
    end
  end

  // Symmetric clamp keeps each magnitude below 2^(ACC_W-1), so the sum fits ACC_W+1 bits.
  always_comb begin
    mag_c = (ACC_W+1)'(abs_val(32'(s1_i))) + (ACC_W+1)'(abs_val(32'(s1_q)));
  end

  // Stage 2: present results and pulse out_valid; values hold until the next dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      I_acc       <= '0;
      Q_acc       <= '0;
      mag         <= '0;
      over_thresh <= 1'b0;
      sat         <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        I_acc       <= s1_i;
        Q_acc       <= s1_q;
        mag         <= mag_c;
        over_thresh <= (mag_c >= {1'b0, s1_thr});
        sat         <= s1_sat;
      end
    end
  end

endmodule

// File: tb/tb_despread_integrator.sv
// Directed bench with a behavioural window model feeding a scoreboard of expected dumps.
// Latency: dumps are expected exactly two cycles after the last chip's cycle.
// Backpressure: n/a.
module tb_despread_integrator;

  localparam int IN_W  = 2;
  localparam int ACC_W = 8;
  localparam int LEN_W = 10;
  localparam int LIM   = (1 << (ACC_W - 1)) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        int_len;
  logic [ACC_W-1:0]        threshold;
  logic                    in_valid;
  logic signed [IN_W-1:0]  I_in;
  logic signed [IN_W-1:0]  Q_in;
  logic                    local_code;
  logic                    busy;
  logic                    out_valid;
  logic signed [ACC_W-1:0] I_acc;
  logic signed [ACC_W-1:0] Q_acc;
  logic [ACC_W:0]          mag;
  logic                    over_thresh;
  logic                    sat;

  despread_integrator #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .int_len     (int_len),
    .threshold   (threshold),
    .in_valid    (in_valid),
    .I_in        (I_in),
    .Q_in        (Q_in),
    .local_code  (local_code),
    .busy        (busy),
    .out_valid   (out_valid),
    .I_acc       (I_acc),
    .Q_acc       (Q_acc),
    .mag         (mag),
    .over_thresh (over_thresh),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int i;
    int q;
    int mag;
    int ovr;
    int sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference window state.
  int m_i, m_q, m_cnt, m_len, m_thr, m_sat, m_run;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, inout int hit);
    if (v > LIM)  begin hit = 1; return LIM;  end
    if (v < -LIM) begin hit = 1; return -LIM; end
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear();
    m_i = 0; m_q = 0; m_cnt = 0; m_sat = 0;
  endtask

  task automatic model_chip(input int i, input int q, input int code, input int k);
    exp_t e;
    int   pi, pq;
    if (m_run == 0) return;
    pi = (code != 0) ? i : -i;
    pq = (code != 0) ? q : -q;
    m_i = clamp(m_i + pi, m_sat);
    m_q = clamp(m_q + pq, m_sat);
    m_cnt++;
    if (m_cnt == m_len) begin
      e.i   = m_i;
      e.q   = m_q;
      e.mag = iabs(m_i) + iabs(m_q);
      e.ovr = (e.mag >= m_thr) ? 1 : 0;
      e.sat = m_sat;
      e.cyc = k + 2;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int thr);
    start = 1'b1; int_len = LEN_W'(len); threshold = ACC_W'(thr); in_valid = 1'b0;
    m_run = 1; m_len = (len == 0) ? 1 : len; m_thr = thr; model_clear();
    step();
    start = 1'b0;
  endtask

  task automatic chip(input int i, input int q, input int code);
    in_valid = 1'b1; I_in = IN_W'(i); Q_in = IN_W'(q); local_code = (code != 0);
    model_chip(i, q, code, cyc);
    step();
    in_valid = 1'b0;
  endtask

  // Chip presented together with start: start wins, chip discarded.
  task automatic start_with_chip(input int len, input int thr, input int i, input int q);
    in_valid = 1'b1; I_in = IN_W'(i); Q_in = IN_W'(q); local_code = 1'b1;
    start = 1'b1; int_len = LEN_W'(len); threshold = ACC_W'(thr);
    m_run = 1; m_len = (len == 0) ? 1 : len; m_thr = thr; model_clear();
    step();
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic bubbles(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard side: compare each dump and flag overdue or unexpected ones.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("dump_missing_at_cycle", cyc, e.cyc);
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("dump_latency", cyc, e.cyc);
        check("I_acc", I_acc, e.i);
        check("Q_acc", Q_acc, e.q);
        check("mag", mag, e.mag);
        check("over_thresh", over_thresh, e.ovr);
        check("sat", sat, e.sat);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; int_len = '0; threshold = '0; in_valid = 1'b0;
    I_in = '0; Q_in = '0; local_code = 1'b0;
    m_run = 0; m_len = 1; m_thr = 0; model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_I_acc", I_acc, 0);
    check("rst_Q_acc", Q_acc, 0);
    check("rst_mag", mag, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    step();

    // Basic window, then a bubbled -2 x code 0 window with no restart.
    do_start(4, 100);
    check("busy_after_start", busy, 1);
    repeat (4) chip(1, -1, 1);
    for (int n = 0; n < 4; n++) begin
      chip(-2, 0, 0);
      bubbles(n + 1);
    end
    bubbles(3);

    // Positive saturation, then a clean short window.
    do_start(130, 100);
    repeat (130) chip(1, 0, 1);
    bubbles(3);
    do_start(2, 100);
    repeat (2) chip(1, 0, 1);
    bubbles(3);

    // Negative saturation on I with Q unsaturated.
    do_start(70, 200);
    repeat (70) chip(-2, 1, 1);
    bubbles(3);

    // Threshold boundary: mag 8 meets, mag 7 misses.
    do_start(4, 8);
    repeat (4) chip(1, -1, 1);
    repeat (3) chip(1, -1, 1);
    chip(1, 0, 1);
    bubbles(3);

    // Restart aborts a partial window.
    do_start(4, 0);
    repeat (2) chip(1, 1, 1);
    do_start(4, 0);
    repeat (4) chip(1, 0, 1);
    bubbles(3);

    // int_len = 0 acts as 1: one dump per chip, back to back.
    do_start(0, 0);
    chip(1, 0, 1);
    chip(-1, 1, 1);
    chip(1, 1, 0);
    bubbles(3);

    // Dump already in stage 1 completes across a restart.
    do_start(1, 5);
    chip(1, 1, 1);
    do_start(4, 5);
    repeat (4) chip(-1, 1, 1);
    bubbles(3);

    // Start coincident with the dump-triggering chip suppresses that dump.
    do_start(2, 0);
    chip(1, 0, 1);
    start_with_chip(2, 0, 1, 0);
    chip(-1, 0, 1);
    chip(-1, -1, 1);
    bubbles(3);

    // Reset the cycle after a last chip cancels the dump and idles the block.
    do_start(4, 0);
    repeat (4) chip(1, 1, 1);
    sb.delete();
    m_run = 0; model_clear();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_I_acc", I_acc, 0);
    check("post_rst_Q_acc", Q_acc, 0);
    check("post_rst_mag", mag, 0);
    check("post_rst_sat", sat, 0);
    check("post_rst_over_thresh", over_thresh, 0);
    repeat (5) chip(1, 1, 1);
    bubbles(4);
    check("idle_busy", busy, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
